mem_write_checker: RTL
======================

# mem_write_checker

Synthesizable, parametrised self-checking monitor for the processor's data-memory write bus (`memwrite`, `dataadr`, `writedata`). It holds a programmable table of expected (address, data) stores, matches the stores the core issues in order, and bounds the run with a cycle timeout. It reports pass or fail with a cause, the failing index and cycle and store counts. It sits beside `top` in simulation benches and FPGA bring-up builds. It replaces single hard-coded end-of-test address/value checks.

## Interface
- `DATA_W`, 32: width of `writedata` and expected data.
- `ADDR_W`, 32: width of `dataadr` and expected address.
- `NUM_CHECKS`, 8: depth of the expected-store table; must be ≥1.
- `TIMEOUT`, 4096: cycles allowed in RUN before a timeout failure; must be ≥1.
- `STRICT`, 0: 1 = any store to an address other than the next expected one is a failure; 0 = such stores are ignored.
- `IDX_W`, derived: `$clog2(NUM_CHECKS+1)`; width of `cfg_len` and `fail_idx`.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; forces IDLE and clears all outputs.
- `cfg_we`  in  1  writes table entry `cfg_idx`; honoured only in IDLE, PASS or FAIL.
- `cfg_idx`  in  `$clog2(NUM_CHECKS)`  table entry index.
- `cfg_addr`  in  `ADDR_W`  expected store address.
- `cfg_data`  in  `DATA_W`  expected store data.
- `cfg_len`  in  `IDX_W`  number of active entries; sampled on `start`; values above `NUM_CHECKS` are clamped to `NUM_CHECKS`.
- `start`  in  1  one-cycle pulse; begins a run.
- `memwrite`  in  1  core store strobe.
- `dataadr`  in  `ADDR_W`  store address.
- `writedata`  in  `DATA_W`  store data.
- `done`  out  1  high in PASS or FAIL.
- `pass`  out  1  high in PASS only.
- `fail_code`  out  2  0 none, 1 data mismatch, 2 unexpected address (STRICT), 3 timeout.
- `fail_idx`  out  `IDX_W`  table pointer value when failure occurred.
- `cycle_cnt`  out  32  cycles spent in RUN; saturates at all-ones.
- `store_cnt`  out  16  `memwrite` cycles seen in RUN; saturates.

## Operation
- States: IDLE, RUN, PASS, FAIL (reset → IDLE).
- IDLE/PASS/FAIL + `start`:
  - Clears the pointer, counters, `fail_code` and `fail_idx`.
  - Latches the clamped `cfg_len`.
  - Goes to RUN. If the latched length is 0, goes directly to PASS.
- RUN, per cycle with `memwrite`=1, where `ptr` is the table pointer:
  - `dataadr` == `exp_addr[ptr]` and `writedata` == `exp_data[ptr]`: `ptr`+1; if `ptr`+1 == length → PASS.
  - `dataadr` == `exp_addr[ptr]` and data differs: FAIL, code 1.
  - Address differs, STRICT=1: FAIL, code 2.
  - Address differs, STRICT=0: store ignored.
- RUN and `cycle_cnt`+1 == TIMEOUT, with no transition caused by this cycle's store → FAIL, code 3.
- Priority in the same cycle: store evaluation beats timeout. A completing store gives PASS; a mismatching store gives code 1, not 3.
- `start` in RUN: ignored. `cfg_we` in RUN: ignored (the table is stable during a run).
- Comparisons use `===` semantics in simulation. X on `dataadr`/`writedata` while `memwrite`=1 counts as a mismatch.
- PASS and FAIL hold until `reset` or `start`.

## Timing
- Reset values: `done`=0, `pass`=0, `fail_code`=0, `fail_idx`=0, `cycle_cnt`=0, `store_cnt`=0. The table contents are not reset.
- `start` at edge N → RUN from N. The first store sampled is at edge N+1.
- A store sampled at edge K is reflected in `done`/`pass`/`fail_*` after edge K; all outputs are registered.
- Timeout fires at the edge where `cycle_cnt` would reach TIMEOUT.
- `cycle_cnt` counts from 0 and increments on every RUN edge, including the terminating one.
- `reset` mid-run: the next edge gives IDLE, all outputs 0, no pass/fail reported.
- Table write at edge K is visible to a `start` at edge K+1 or later.

## Structure
- Package `mwc_pkg`: state enum `mwc_state_t` and `mwc_fail_t` (NONE, DATA, ADDR, TIMEOUT).
- Sub-module `mwc_expect_table`: `NUM_CHECKS`×(`ADDR_W`+`DATA_W`) register file with a write port and an asynchronous read at `ptr`.
- Top module: FSM, pointer and saturating counters.

## Test plan
- Default params, table {84:7}, `cfg_len`=1, `start`, stores 80:3 then 84:7 → PASS one edge after the 84 store; `fail_code`=0; `store_cnt`=2.
- Table {16:0, 20:5}, `cfg_len`=2, stores 16:0, 20:6 → FAIL, `fail_code`=1, `fail_idx`=1.
- STRICT=1, table {84:7}, store 80:3 → FAIL, code 2, `fail_idx`=0.
- TIMEOUT=10, no stores → FAIL, code 3, after exactly 10 RUN edges, with `cycle_cnt`=10. Repeat with the matching store on edge 10 → PASS.
- `reset` asserted during RUN after 1 of 2 matches → all outputs 0. A new `start` re-runs from index 0 and passes.
- `cfg_len`=0 → PASS after one edge. `cfg_len`=15 with NUM_CHECKS=8 is clamped to 8; `cfg_we` during RUN leaves the table unchanged.

Source files
------------

// File: rtl/mwc_pkg.sv
// Shared types and helpers for the data-memory write checker.
package mwc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } mwc_state_t;

  typedef enum logic [1:0] {
    FC_NONE    = 2'd0,
    FC_DATA    = 2'd1,
    FC_ADDR    = 2'd2,
    FC_TIMEOUT = 2'd3
  } mwc_fail_t;

  localparam int unsigned CYC_W   = 32;
  localparam int unsigned STORE_W = 16;

  // Index width for a table of n entries; never narrower than one bit.
  function automatic int unsigned idx_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mwc_expect_table.sv
// Expected-store table: one write port, asynchronous read at the run pointer.
module mwc_expect_table #(
  parameter int unsigned NUM_CHECKS = 8,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned CI_W       = 3
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [CI_W-1:0]   i_widx,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [CI_W-1:0]   i_ridx,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_data
);

  logic [ADDR_W-1:0] r_addr [NUM_CHECKS];
  logic [DATA_W-1:0] r_data [NUM_CHECKS];

  // Table contents are configuration, so they are intentionally not reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_addr[i_widx] <= i_waddr;
      r_data[i_widx] <= i_wdata;
    end
  end

  assign o_addr = r_addr[i_ridx];
  assign o_data = r_data[i_ridx];

endmodule

// File: rtl/mem_write_checker.sv
// Monitors the core's store bus against an ordered table of expected stores.
module mem_write_checker
  import mwc_pkg::*;
#(
  parameter  int unsigned DATA_W     = 32,
  parameter  int unsigned ADDR_W     = 32,
  parameter  int unsigned NUM_CHECKS = 8,
  parameter  int unsigned TIMEOUT    = 4096,
  parameter  int unsigned STRICT     = 0,
  localparam int unsigned IDX_W      = $clog2(NUM_CHECKS + 1),
  localparam int unsigned CI_W       = idx_bits(NUM_CHECKS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_we,
  input  logic [CI_W-1:0]    cfg_idx,
  input  logic [ADDR_W-1:0]  cfg_addr,
  input  logic [DATA_W-1:0]  cfg_data,
  input  logic [IDX_W-1:0]   cfg_len,
  input  logic               start,
  input  logic               memwrite,
  input  logic [ADDR_W-1:0]  dataadr,
  input  logic [DATA_W-1:0]  writedata,
  output logic               done,
  output logic               pass,
  output logic [1:0]         fail_code,
  output logic [IDX_W-1:0]   fail_idx,
  output logic [CYC_W-1:0]   cycle_cnt,
  output logic [STORE_W-1:0] store_cnt
);

  mwc_state_t         r_state;
  mwc_fail_t          r_fail_code;
  logic               r_done;
  logic               r_pass;
  logic [IDX_W-1:0]   r_fail_idx;
  logic [CYC_W-1:0]   r_cycle_cnt;
  logic [STORE_W-1:0] r_store_cnt;
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   r_len;

  logic [ADDR_W-1:0]  w_exp_addr;
  logic [DATA_W-1:0]  w_exp_data;
  logic               w_tbl_we;
  logic [IDX_W-1:0]   w_len_clamp;
  logic               w_addr_hit;
  logic               w_data_hit;
  logic [IDX_W-1:0]   w_ptr_inc;
  logic [CYC_W:0]     w_cyc_inc;
  logic               w_timeout;
  logic [CYC_W-1:0]   w_cyc_next;
  logic [STORE_W-1:0] w_store_next;

  // The table is frozen while a run is in progress.
  assign w_tbl_we = cfg_we && (r_state != ST_RUN);

  mwc_expect_table #(
    .NUM_CHECKS (NUM_CHECKS),
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .CI_W       (CI_W)
  ) u_table (
    .clk     (clk),
    .i_we    (w_tbl_we),
    .i_widx  (cfg_idx),
    .i_waddr (cfg_addr),
    .i_wdata (cfg_data),
    .i_ridx  (r_ptr[CI_W-1:0]),
    .o_addr  (w_exp_addr),
    .o_data  (w_exp_data)
  );

  // Length clamp, store compare (X-aware) and saturating counter next values.
  always_comb begin
    w_len_clamp  = (cfg_len > IDX_W'(NUM_CHECKS)) ? IDX_W'(NUM_CHECKS) : cfg_len;
    w_addr_hit   = (dataadr === w_exp_addr);
    w_data_hit   = (writedata === w_exp_data);
    w_ptr_inc    = r_ptr + IDX_W'(1);
    w_cyc_inc    = {1'b0, r_cycle_cnt} + (CYC_W + 1)'(1);
    w_timeout    = (w_cyc_inc == (CYC_W + 1)'(TIMEOUT));
    w_cyc_next   = (&r_cycle_cnt) ? r_cycle_cnt : w_cyc_inc[CYC_W-1:0];
    w_store_next = (&r_store_cnt) ? r_store_cnt : r_store_cnt + STORE_W'(1);
  end

  // Run-control FSM with its registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_fail_code <= FC_NONE;
      r_fail_idx  <= '0;
      r_cycle_cnt <= '0;
      r_store_cnt <= '0;
      r_ptr       <= '0;
      r_len       <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_PASS, ST_FAIL: begin
          if (start) begin
            r_ptr       <= '0;
            r_cycle_cnt <= '0;
            r_store_cnt <= '0;
            r_fail_code <= FC_NONE;
            r_fail_idx  <= '0;
            r_len       <= w_len_clamp;
            if (w_len_clamp == '0) begin
              r_state <= ST_PASS;
              r_done  <= 1'b1;
              r_pass  <= 1'b1;
            end else begin
              r_state <= ST_RUN;
              r_done  <= 1'b0;
              r_pass  <= 1'b0;
            end
          end
        end
        ST_RUN: begin
          r_cycle_cnt <= w_cyc_next;
          if (memwrite) begin
            r_store_cnt <= w_store_next;
          end
          if (memwrite && w_addr_hit && w_data_hit) begin
            r_ptr <= w_ptr_inc;
          end
          // Store outcome takes priority over the timeout in the same cycle.
          if (memwrite && w_addr_hit && w_data_hit && (w_ptr_inc == r_len)) begin
            r_state <= ST_PASS;
            r_done  <= 1'b1;
            r_pass  <= 1'b1;
          end else if (memwrite && w_addr_hit && !w_data_hit) begin
            r_state     <= ST_FAIL;
            r_done      <= 1'b1;
            r_fail_code <= FC_DATA;
            r_fail_idx  <= r_ptr;
          end else if (memwrite && !w_addr_hit && (STRICT != 0)) begin
            r_state     <= ST_FAIL;
            r_done      <= 1'b1;
            r_fail_code <= FC_ADDR;
            r_fail_idx  <= r_ptr;
          end else if (w_timeout) begin
            r_state     <= ST_FAIL;
            r_done      <= 1'b1;
            r_fail_code <= FC_TIMEOUT;
            r_fail_idx  <= (memwrite && w_addr_hit) ? w_ptr_inc : r_ptr;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign done      = r_done;
  assign pass      = r_pass;
  assign fail_code = r_fail_code;
  assign fail_idx  = r_fail_idx;
  assign cycle_cnt = r_cycle_cnt;
  assign store_cnt = r_store_cnt;

endmodule
